// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
// Imported by the interface, RAM array and controller.
package dmem_pkg;

   localparam int WORD_W = 32;
   localparam int LAT_W  = 4;
   localparam int OFS_W  = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic wr;
      logic rd;
      logic err;
   } op_t;

   // Both strobes resolve to a store; the load side is then suppressed.
   function automatic op_t decode_op(
      input logic             rd,
      input logic             wr,
      input logic [OFS_W-1:0] ofs
   );
      op_t o;
      o.wr  = wr;
      o.rd  = rd & ~wr;
      o.err = (|ofs) | (rd & wr);
      return o;
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the EX/MEM register and the
// data-memory responder.
interface dmem_responder_if;
   import dmem_pkg::*;

   logic              MemRead_i;
   logic              MemWrite_i;
   logic [31:0]       Address_i;
   logic [WORD_W-1:0] Write_data_i;
   logic [WORD_W-1:0] Read_data_o;
   logic              pcEnable_o;
   logic              err_o;

   modport master (
      output MemRead_i,
      output MemWrite_i,
      output Address_i,
      output Write_data_i,
      input  Read_data_o,
      input  pcEnable_o,
      input  err_o
   );

   modport slave (
      input  MemRead_i,
      input  MemWrite_i,
      input  Address_i,
      input  Write_data_i,
      output Read_data_o,
      output pcEnable_o,
      output err_o
   );

endinterface

// File: rtl/dmem_array.sv
// Word-wide data RAM: synchronous write, synchronous read-before-write.
// Contents are never reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter  int DEPTH = 1024,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we) begin
         mem[idx] <= wdata;
      end
      rdata <= mem[idx];
   end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: fixed-latency word RAM access that
// stalls the pipeline via pcEnable_o until the access completes.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   dmem_responder_if.slave  bus
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [LAT_W-1:0] CNT_INIT = LAT_W'(LATENCY - 1);
   localparam logic [LAT_W-1:0] CNT_LAST = LAT_W'(1);

   state_t            state;
   state_t            nxt;
   logic [LAT_W-1:0]  cnt;
   op_t               op_in;
   op_t               op_q;
   op_t               op_m;
   logic [IDX_W-1:0]  idx_in;
   logic [IDX_W-1:0]  idx_q;
   logic [IDX_W-1:0]  idx_m;
   logic [WORD_W-1:0] data_q;
   logic [WORD_W-1:0] data_m;
   logic [WORD_W-1:0] rdata;
   logic [WORD_W-1:0] rd_q;
   logic              err_q;
   logic              req;
   logic              accept;
   logic              commit;
   logic              we;
   logic              pc_en;
   logic              rd_done;
   logic              unused_addr;

   assign req    = bus.MemRead_i | bus.MemWrite_i;
   assign accept = (state == IDLE) & req;
   assign op_in  = decode_op(bus.MemRead_i, bus.MemWrite_i,
                             bus.Address_i[OFS_W-1:0]);
   assign idx_in = bus.Address_i[IDX_W+OFS_W-1:OFS_W];

   // Upper address bits wrap the index; they are intentionally dropped.
   assign unused_addr = ^bus.Address_i[31:IDX_W+OFS_W];

   // Live request fields bypass the latches so a one-cycle latency can
   // commit on the same edge that accepts the request.
   assign op_m   = accept ? op_in : op_q;
   assign idx_m  = accept ? idx_in : idx_q;
   assign data_m = accept ? bus.Write_data_i : data_q;

   assign commit = (nxt == DONE) & ~rst_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE: begin
            if (req) begin
               nxt = (LATENCY > 1) ? BUSY : DONE;
            end
         end
         BUSY: begin
            if (cnt == CNT_LAST) begin
               nxt = DONE;
            end
         end
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      pc_en   = 1'b0;
      we      = 1'b0;
      rd_done = 1'b0;
      unique case (state)
         IDLE:    pc_en = ~req;
         BUSY:    pc_en = 1'b0;
         DONE: begin
            pc_en   = 1'b1;
            rd_done = op_q.rd;
         end
         default: pc_en = 1'b0;
      endcase
      we = commit & op_m.wr;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt    <= '0;
         op_q   <= '0;
         idx_q  <= '0;
         data_q <= '0;
         rd_q   <= '0;
         err_q  <= 1'b0;
      end else begin
         if (accept) begin
            cnt    <= CNT_INIT;
            op_q   <= op_in;
            idx_q  <= idx_in;
            data_q <= bus.Write_data_i;
         end else if (state == BUSY) begin
            cnt <= cnt - 1'b1;
         end
         err_q <= commit & op_m.err;
         if (rd_done) begin
            rd_q <= rdata;
         end
      end
   end

   dmem_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk_i (clk_i),
      .we    (we),
      .idx   (idx_m),
      .wdata (data_m),
      .rdata (rdata)
   );

   // Load data appears straight from the RAM register in DONE and is
   // held in rd_q until the next load completes.
   assign bus.Read_data_o = rd_done ? rdata : rd_q;
   assign bus.pcEnable_o  = pc_en;
   assign bus.err_o       = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: a LATENCY=3 and a LATENCY=1 responder checked
// against a word-array model with directed and random accesses.
module tb_dmem_responder;

   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] model [int];
   logic [31:0] rd_exp [2];

   dmem_responder_if ifa ();
   dmem_responder_if ifb ();

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(3)) dut_a (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (ifa.slave)
   );

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_b (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (ifb.slave)
   );

   always #5 clk = ~clk;

   function automatic logic pe(input int s);
      return (s != 0) ? ifb.pcEnable_o : ifa.pcEnable_o;
   endfunction

   function automatic logic er(input int s);
      return (s != 0) ? ifb.err_o : ifa.err_o;
   endfunction

   function automatic logic [31:0] rdv(input int s);
      return (s != 0) ? ifb.Read_data_o : ifa.Read_data_o;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int s, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d);
      if (s != 0) begin
         ifb.MemRead_i    = rd;
         ifb.MemWrite_i   = wr;
         ifb.Address_i    = a;
         ifb.Write_data_i = d;
      end else begin
         ifa.MemRead_i    = rd;
         ifa.MemWrite_i   = wr;
         ifa.Address_i    = a;
         ifa.Write_data_i = d;
      end
   endtask

   // One access: count low pcEnable cycles, then check the DONE cycle.
   task automatic acc(input int s, input bit rd, input bit wr,
                      input logic [31:0] a, input logic [31:0] d);
      int   lows;
      int   key;
      int   lat;
      logic exp_err;
      lat     = (s != 0) ? 1 : 3;
      key     = s * DEPTH + int'((a / 4) % DEPTH);
      exp_err = ((a % 4) != 0) || (rd && wr);
      if (rd && !wr) begin
         rd_exp[s] = model.exists(key) ? model[key] : 32'hx;
      end
      if (wr) begin
         model[key] = d;
      end
      drive(s, rd, wr, a, d);
      lows = 0;
      @(negedge clk);
      while (pe(s) === 1'b0 && lows < 20) begin
         lows++;
         if (er(s) !== 1'b0) begin
            chk("err_in_stall", {31'd0, er(s)}, 32'd0);
         end
         @(negedge clk);
      end
      chk("stall_cycles", lows, lat);
      chk("done_pcen", {31'd0, pe(s)}, 32'd1);
      chk("done_err", {31'd0, er(s)}, {31'd0, exp_err});
      chk("done_rdata", rdv(s), rd_exp[s]);
      @(posedge clk);
      #1;
      drive(s, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int          pool [8];
      logic [31:0] a;
      logic [31:0] hi;
      bit          r;

      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
      rd_exp[0] = 32'd0;
      rd_exp[1] = 32'd0;

      // Reset pulsed mid-cycle
      #2 rst = 1'b1;
      #1;
      chk("rst_rdata_a", ifa.Read_data_o, 32'd0);
      chk("rst_err_a", {31'd0, ifa.err_o}, 32'd0);
      chk("rst_rdata_b", ifb.Read_data_o, 32'd0);
      #9 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("idle_pcen_a", {31'd0, ifa.pcEnable_o}, 32'd1);
         chk("idle_pcen_b", {31'd0, ifb.pcEnable_o}, 32'd1);
         chk("idle_rdata_a", ifa.Read_data_o, 32'd0);
      end
      @(posedge clk);
      #1;

      // Store then load, back to back
      acc(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      acc(0, 1'b1, 1'b0, 32'h10, 32'h0);

      // Read-after-write ordering
      acc(0, 1'b0, 1'b1, 32'h20, 32'h11111111);
      acc(0, 1'b0, 1'b1, 32'h20, 32'h22222222);
      acc(0, 1'b1, 1'b0, 32'h20, 32'h0);
      chk("raw_value", rd_exp[0], 32'h22222222);

      // Misaligned write that also wraps to index 0
      acc(0, 1'b0, 1'b1, 32'h1003, 32'hCAFEF00D);
      acc(0, 1'b1, 1'b0, 32'h0, 32'h0);

      // Both strobes: store, error, load data untouched
      acc(0, 1'b1, 1'b1, 32'h40, 32'h5A5A5A5A);
      acc(0, 1'b1, 1'b0, 32'h40, 32'h0);

      // Reset in the second stall cycle of a store
      acc(0, 1'b0, 1'b1, 32'h80, 32'hAAAAAAAA);
      drive(0, 1'b0, 1'b1, 32'h80, 32'h12345678);
      @(negedge clk);
      @(negedge clk);
      chk("mid_stall", {31'd0, ifa.pcEnable_o}, 32'd0);
      rst = 1'b1;
      #1;
      chk("mid_rst_rdata", ifa.Read_data_o, 32'd0);
      chk("mid_rst_err", {31'd0, ifa.err_o}, 32'd0);
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      chk("mid_rst_idle", {31'd0, ifa.pcEnable_o}, 32'd1);
      model[32'h80 / 4] = 32'hAAAAAAAA;
      rd_exp[0] = 32'd0;
      rd_exp[1] = 32'd0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      acc(0, 1'b1, 1'b0, 32'h80, 32'h0);
      chk("lost_write", rd_exp[0], 32'hAAAAAAAA);

      // Single-cycle latency instance
      acc(1, 1'b0, 1'b1, 32'h4, 32'h0BADF00D);
      acc(1, 1'b1, 1'b0, 32'h4, 32'h0);
      chk("lat1_value", rd_exp[1], 32'h0BADF00D);
      acc(1, 1'b1, 1'b1, 32'h8, 32'h77665544);
      acc(1, 1'b1, 1'b0, 32'h2008, 32'h0);

      // Random traffic over a small pool so addresses collide
      for (int i = 0; i < 8; i++) begin
         pool[i] = int'($urandom_range(0, DEPTH - 1));
         hi = $urandom << 12;
         acc(0, 1'b0, 1'b1, hi | (pool[i] * 4), $urandom);
      end
      for (int i = 0; i < 40; i++) begin
         hi = $urandom << 12;
         a  = hi | (pool[$urandom_range(0, 7)] * 4);
         if ($urandom_range(0, 7) == 0) begin
            a = a | $urandom_range(1, 3);
         end
         r = bit'($urandom_range(0, 1));
         acc(0, r, !r, a, $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
